// File: rtl/temp_stats_pkg.sv
// Shared definitions for the temperature window statistics block:
// FSM encoding, default geometry and the min_out reset pattern.
package temp_stats_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StScan,
      StDiv,
      StDone
   } state_e;

   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefDepth = 10;

   // min_out resets to all ones: every bit takes this value
   localparam logic MinRstBit = 1'b1;

endpackage

// File: rtl/temp_window_ram.sv
// Inferred single-port sample RAM: synchronous write, registered 1-cycle read.
module temp_window_ram
   import temp_stats_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned DEPTH  = DefDepth,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/temp_window_stats.sv
// Sliding-window temperature statistics: stores samples in a circular RAM and,
// after every accepted sample, scans the window for sum/max/min and divides for the average.
module temp_window_stats
   import temp_stats_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned DEPTH  = DefDepth,
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned SUM_W  = DATA_W + $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              stats_valid,
   output logic [SUM_W-1:0]  sum_out,
   output logic [DATA_W-1:0] avg_out,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic [ADDR_W:0]   fill_count
);

   localparam int unsigned FillW = ADDR_W + 1;
   localparam int unsigned CntW  = $clog2(SUM_W);

   localparam logic [FillW-1:0]  FillMax = FillW'(DEPTH);
   localparam logic [ADDR_W-1:0] PtrMax  = ADDR_W'(DEPTH - 1);
   localparam logic [CntW-1:0]   DivLast = CntW'(SUM_W - 1);
   localparam logic [DATA_W-1:0] MinRst  = {DATA_W{MinRstBit}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FillW-1:0]  fill_q, fill_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic [FillW-1:0]  scan_cnt_q, scan_cnt_d;
   logic              rd_vld_q, rd_vld_d;
   logic              first_q, first_d;
   logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
   logic [DATA_W-1:0] acc_max_q, acc_max_d;
   logic [DATA_W-1:0] acc_min_q, acc_min_d;
   logic [SUM_W-1:0]  dq_q, dq_d;
   logic [FillW-1:0]  rem_q, rem_d;
   logic [CntW-1:0]   div_cnt_q, div_cnt_d;
   logic [SUM_W-1:0]  sum_out_q, sum_out_d;
   logic [DATA_W-1:0] avg_q, avg_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic [DATA_W-1:0] min_q, min_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic [FillW:0]    trial;

   temp_window_ram #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk_i  (clk),
      .we_i   (ram_we & ~rst),
      .addr_i (ram_addr),
      .wdata_i(sample_q),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      fill_d     = fill_q;
      sample_d   = sample_q;
      scan_cnt_d = scan_cnt_q;
      rd_vld_d   = 1'b0;
      first_d    = first_q;
      acc_sum_d  = acc_sum_q;
      acc_max_d  = acc_max_q;
      acc_min_d  = acc_min_q;
      dq_d       = dq_q;
      rem_d      = rem_q;
      div_cnt_d  = div_cnt_q;
      sum_out_d  = sum_out_q;
      avg_d      = avg_q;
      max_d      = max_q;
      min_d      = min_q;
      ram_we     = 1'b0;
      ram_addr   = wr_ptr_q;
      // Restoring division: shift the next dividend bit into the partial remainder
      trial      = {rem_q, dq_q[SUM_W-1]};

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sample_d = in_data;
               state_d  = StWrite;
            end
         end
         StWrite: begin
            ram_we     = 1'b1;
            wr_ptr_d   = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
            if (fill_q != FillMax) begin
               fill_d = fill_q + 1'b1;
            end
            scan_cnt_d = '0;
            first_d    = 1'b1;
            acc_sum_d  = '0;
            state_d    = StScan;
         end
         StScan: begin
            if (scan_cnt_q != fill_q) begin
               ram_addr   = scan_cnt_q[ADDR_W-1:0];
               rd_vld_d   = 1'b1;
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
            if (rd_vld_q) begin
               acc_sum_d = acc_sum_q + SUM_W'(ram_rdata);
               if (first_q || (ram_rdata > acc_max_q)) begin
                  acc_max_d = ram_rdata;
               end
               if (first_q || (ram_rdata < acc_min_q)) begin
                  acc_min_d = ram_rdata;
               end
               first_d = 1'b0;
            end
            if (scan_cnt_q == fill_q) begin
               dq_d      = acc_sum_d;
               rem_d     = '0;
               div_cnt_d = '0;
               state_d   = StDiv;
            end
         end
         StDiv: begin
            if (trial >= {1'b0, fill_q}) begin
               rem_d = trial[FillW-1:0] - fill_q;
               dq_d  = {dq_q[SUM_W-2:0], 1'b1};
            end else begin
               rem_d = trial[FillW-1:0];
               dq_d  = {dq_q[SUM_W-2:0], 1'b0};
            end
            div_cnt_d = div_cnt_q + 1'b1;
            // Publish on entry to DONE so the outputs are fresh while stats_valid is high
            if (div_cnt_q == DivLast) begin
               sum_out_d = acc_sum_q;
               avg_d     = dq_d[DATA_W-1:0];
               max_d     = acc_max_q;
               min_d     = acc_min_q;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (clear) begin
         state_d   = StIdle;
         wr_ptr_d  = '0;
         fill_d    = '0;
         sum_out_d = '0;
         avg_d     = '0;
         max_d     = '0;
         min_d     = MinRst;
         ram_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         sample_q   <= '0;
         scan_cnt_q <= '0;
         rd_vld_q   <= 1'b0;
         first_q    <= 1'b0;
         acc_sum_q  <= '0;
         acc_max_q  <= '0;
         acc_min_q  <= '0;
         dq_q       <= '0;
         rem_q      <= '0;
         div_cnt_q  <= '0;
         sum_out_q  <= '0;
         avg_q      <= '0;
         max_q      <= '0;
         min_q      <= MinRst;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_q     <= fill_d;
         sample_q   <= sample_d;
         scan_cnt_q <= scan_cnt_d;
         rd_vld_q   <= rd_vld_d;
         first_q    <= first_d;
         acc_sum_q  <= acc_sum_d;
         acc_max_q  <= acc_max_d;
         acc_min_q  <= acc_min_d;
         dq_q       <= dq_d;
         rem_q      <= rem_d;
         div_cnt_q  <= div_cnt_d;
         sum_out_q  <= sum_out_d;
         avg_q      <= avg_d;
         max_q      <= max_d;
         min_q      <= min_d;
      end
   end

   assign in_ready    = (state_q == StIdle);
   assign busy        = ~in_ready;
   assign stats_valid = (state_q == StDone);
   assign sum_out     = sum_out_q;
   assign avg_out     = avg_q;
   assign max_out     = max_q;
   assign min_out     = min_q;
   assign fill_count  = fill_q;

endmodule

// File: tb/tb_temp_window_stats.sv
// Directed bench for temp_window_stats at default geometry (DATA_W=8, DEPTH=10, SUM_W=12).
module tb_temp_window_stats;

   logic        clk = 1'b0;
   logic        rst, clear, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, busy, stats_valid;
   logic [11:0] sum_out;
   logic [7:0]  avg_out, max_out, min_out;
   logic [4:0]  fill_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit clr;
      int sample;
      int sum;
      int avg;
      int mx;
      int mn;
      int fill;
   } vec_t;

   localparam int NumVec = 24;
   vec_t vecs[NumVec];

   temp_window_stats dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .busy       (busy),
      .stats_valid(stats_valid),
      .sum_out    (sum_out),
      .avg_out    (avg_out),
      .max_out    (max_out),
      .min_out    (min_out),
      .fill_count (fill_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, " in_ready"}, int'(in_ready), 1);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " stats_valid"}, int'(stats_valid), 0);
      chk({tag, " sum"}, int'(sum_out), 0);
      chk({tag, " avg"}, int'(avg_out), 0);
      chk({tag, " max"}, int'(max_out), 0);
      chk({tag, " min"}, int'(min_out), 255);
      chk({tag, " fill"}, int'(fill_count), 0);
   endtask

   task automatic set_vec(input int i, input bit c, input int v, input int s, input int a,
                          input int mx, input int mn, input int f);
      vecs[i] = '{clr: c, sample: v, sum: s, avg: a, mx: mx, mn: mn, fill: f};
   endtask

   // Offer one sample, optionally clearing first; hold keeps in_valid high afterwards.
   task automatic run_sample(input vec_t t, input bit hold, input string tag);
      int          c;
      bit          ready_bad, hold_bad;
      logic [11:0] prev;
      in_valid = 1'b1;
      in_data  = 8'(t.sample);
      c = 0;
      while (!in_ready && c < 50) begin
         tick();
         c++;
      end
      chk({tag, " ready_wait"}, int'(in_ready), 1);
      if (t.clr) begin
         clear = 1'b1;
         tick();
         clear = 1'b0;
         chk({tag, " clr fill"}, int'(fill_count), 0);
         chk({tag, " clr ready"}, int'(in_ready), 1);
         chk({tag, " clr sum"}, int'(sum_out), 0);
      end
      prev = sum_out;
      tick();
      if (!hold) in_valid = 1'b0;
      c = 1;
      ready_bad = 1'b0;
      hold_bad  = 1'b0;
      while (!stats_valid && c < 100) begin
         if (in_ready || !busy) ready_bad = 1'b1;
         if (sum_out != prev) hold_bad = 1'b1;
         tick();
         c++;
      end
      if (in_ready) ready_bad = 1'b1;
      chk({tag, " stats_valid"}, int'(stats_valid), 1);
      chk({tag, " latency"}, c, t.fill + 15);
      chk({tag, " busy_window"}, int'(ready_bad), 0);
      chk({tag, " out_stable"}, int'(hold_bad), 0);
      chk({tag, " sum"}, int'(sum_out), t.sum);
      chk({tag, " avg"}, int'(avg_out), t.avg);
      chk({tag, " max"}, int'(max_out), t.mx);
      chk({tag, " min"}, int'(min_out), t.mn);
      chk({tag, " fill"}, int'(fill_count), t.fill);
      if (!hold) begin
         tick();
         chk({tag, " ready_after"}, int'(in_ready), 1);
         chk({tag, " pulse_one"}, int'(stats_valid), 0);
         chk({tag, " sum_hold"}, int'(sum_out), t.sum);
      end
   endtask

   initial begin
      vec_t t;
      bit   sv_seen;

      set_vec(0, 0, 25, 25, 25, 25, 25, 1);
      set_vec(1, 1, 10, 10, 10, 10, 10, 1);
      set_vec(2, 0, 20, 30, 15, 20, 10, 2);
      set_vec(3, 0, 30, 60, 20, 30, 10, 3);
      set_vec(4, 0, 40, 100, 25, 40, 10, 4);
      set_vec(5, 0, 50, 150, 30, 50, 10, 5);
      set_vec(6, 0, 60, 210, 35, 60, 10, 6);
      set_vec(7, 0, 70, 280, 40, 70, 10, 7);
      set_vec(8, 0, 80, 360, 45, 80, 10, 8);
      set_vec(9, 0, 90, 450, 50, 90, 10, 9);
      set_vec(10, 0, 100, 550, 55, 100, 10, 10);
      set_vec(11, 0, 200, 740, 74, 200, 20, 10);
      set_vec(12, 0, 255, 975, 97, 255, 30, 10);
      set_vec(13, 0, 255, 1200, 120, 255, 40, 10);
      set_vec(14, 0, 255, 1415, 141, 255, 50, 10);
      set_vec(15, 0, 255, 1620, 162, 255, 60, 10);
      set_vec(16, 0, 255, 1815, 181, 255, 70, 10);
      set_vec(17, 0, 255, 2000, 200, 255, 80, 10);
      set_vec(18, 0, 255, 2175, 217, 255, 90, 10);
      set_vec(19, 0, 255, 2340, 234, 255, 100, 10);
      set_vec(20, 0, 255, 2495, 249, 255, 200, 10);
      set_vec(21, 0, 255, 2550, 255, 255, 255, 10);
      set_vec(22, 1, 1, 1, 1, 1, 1, 1);
      set_vec(23, 0, 2, 3, 1, 2, 1, 2);

      rst = 1'b1;
      clear = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      tick();
      tick();
      rst = 1'b0;
      chk_idle_reset("reset");

      run_sample(vecs[0], 1'b0, "single25");
      for (int i = 1; i < NumVec; i++) begin
         run_sample(vecs[i], (i != NumVec - 1), $sformatf("vec%0d", i));
      end

      // Clear during the third SCAN cycle (fill would be 3)
      in_valid = 1'b1;
      in_data  = 8'd9;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      chk("scan3 busy", int'(busy), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_idle_reset("clr_scan");
      sv_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (stats_valid) sv_seen = 1'b1;
         tick();
      end
      chk("clr_scan no_valid", int'(sv_seen), 0);
      t = '{clr: 0, sample: 7, sum: 7, avg: 7, mx: 7, mn: 7, fill: 1};
      run_sample(t, 1'b0, "after_clr7");

      // Reset during DIV (n=2: DIV spans cycles 5..16) with a sample offered
      in_valid = 1'b1;
      in_data  = 8'd5;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("div busy", int'(busy), 1);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'd99;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      chk_idle_reset("rst_div");
      sv_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (stats_valid || busy) sv_seen = 1'b1;
         tick();
      end
      chk("rst_div quiet", int'(sv_seen), 0);
      chk("rst_div fill", int'(fill_count), 0);

      // clear and in_valid together in IDLE: sample dropped
      in_valid = 1'b1;
      in_data = 8'd50;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("clr_idle fill", int'(fill_count), 0);
      chk("clr_idle busy", int'(busy), 0);
      t = '{clr: 0, sample: 42, sum: 42, avg: 42, mx: 42, mn: 42, fill: 1};
      run_sample(t, 1'b0, "final42");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
